npc_seq_ctrl: RTL and testbench

Multi-cycle sequencer for the NPC core datapath (PC register, register file, ALU/LSU). It fetches over a req/gnt/rvalid instruction bus and latches the instruction. It steps the datapath through execute, memory and write-back, gating the register-file write enable and the PC update. It halts on ebreak, watchdog timeout or a misaligned next PC, and replaces the always-enabled single-cycle PC/RF writes.

---
 rtl/npc_pkg.sv | 24 ++
 rtl/npc_seq_ctrl_if.sv | 30 +++
 rtl/npc_bus_wdog.sv | 26 ++
 rtl/npc_seq_ctrl.sv | 95 +++++++++
 tb/tb_npc_seq_ctrl.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/npc_pkg.sv
// npc_pkg: shared state encoding, opcodes and default constants for the NPC sequencer
package npc_pkg;

    typedef enum logic [2:0] {
        ST_FETCH_REQ  = 3'd0,
        ST_FETCH_WAIT = 3'd1,
        ST_EXEC       = 3'd2,
        ST_MEM_REQ    = 3'd3,
        ST_MEM_WAIT   = 3'd4,
        ST_WB         = 3'd5,
        ST_HALT       = 3'd6
    } state_e;

    localparam logic [6:0]  OP_LOAD         = 7'b0000011;
    localparam logic [6:0]  OP_STORE        = 7'b0100011;
    localparam logic [6:0]  OP_BRANCH       = 7'b1100011;
    localparam logic [31:0] DEF_EBREAK_INST = 32'h00100073;
    localparam logic [31:0] DEF_RESET_PC    = 32'h80000000;

    function automatic logic is_mem_op(input logic [6:0] op);
        return (op == OP_LOAD) || (op == OP_STORE);
    endfunction

endpackage

// File: rtl/npc_seq_ctrl_if.sv
// npc_seq_ctrl_if: fetch bus, load/store handshake and datapath control signals of the sequencer
interface npc_seq_ctrl_if;

    logic        ifu_req;
    logic [31:0] ifu_addr;
    logic        ifu_gnt;
    logic        ifu_rvalid;
    logic [31:0] ifu_rdata;
    logic [31:0] inst;
    logic        lsu_req;
    logic        lsu_gnt;
    logic        lsu_rvalid;
    logic [31:0] pc_next;
    logic [31:0] pc;
    logic        rf_wen;
    logic [31:0] retired;
    logic        halted;
    logic        trap;

    modport master (
        output ifu_req, ifu_addr, inst, lsu_req, pc, rf_wen, retired, halted, trap,
        input  ifu_gnt, ifu_rvalid, ifu_rdata, lsu_gnt, lsu_rvalid, pc_next
    );

    modport slave (
        input  ifu_req, ifu_addr, inst, lsu_req, pc, rf_wen, retired, halted, trap,
        output ifu_gnt, ifu_rvalid, ifu_rdata, lsu_gnt, lsu_rvalid, pc_next
    );

endinterface

// File: rtl/npc_bus_wdog.sv
// npc_bus_wdog: 16-bit bus-wait watchdog shared by the fetch and load/store waits
module npc_bus_wdog #(
    parameter logic [15:0] TIMEOUT = 16'd1000
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic expire
);

    logic [15:0] cnt_q, cnt_d;

    // count wait cycles, restarting whenever the sequencer changes state
    always_comb begin
        cnt_d = clr ? 16'd0 : en ? cnt_q + 16'd1 : cnt_q;
    end

    // counter register with synchronous active-low reset
    always_ff @(posedge clk) begin
        cnt_q <= !reset ? 16'd0 : cnt_d;
    end

    assign expire = en && (cnt_q == TIMEOUT - 16'd1);

endmodule

// File: rtl/npc_seq_ctrl.sv
// npc_seq_ctrl: multi-cycle fetch/execute/memory/write-back sequencer for the NPC core
module npc_seq_ctrl
    import npc_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = DEF_RESET_PC,
    parameter logic [15:0] TIMEOUT     = 16'd1000,
    parameter logic [31:0] EBREAK_INST = DEF_EBREAK_INST
) (
    input logic            clk,
    input logic            reset,
    npc_seq_ctrl_if.master bus
);

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] retired_q, retired_d;
    logic        halted_q, halted_d;
    logic        trap_q, trap_d;
    logic        expire;
    logic        waiting;
    logic        wb_ok;
    logic [6:0]  op;

    assign op      = inst_q[6:0];
    assign waiting = state_q inside {ST_FETCH_REQ, ST_FETCH_WAIT, ST_MEM_REQ, ST_MEM_WAIT};
    assign wb_ok   = (state_q == ST_WB) && (bus.pc_next[1:0] == 2'b00);

    npc_bus_wdog #(.TIMEOUT(TIMEOUT)) u_wdog (
        .clk    (clk),
        .reset  (reset),
        .clr    (state_d != state_q),
        .en     (waiting),
        .expire (expire)
    );

    // state register; reset abandons any handshake in flight
    always_ff @(posedge clk) begin
        state_q <= !reset ? ST_FETCH_REQ : state_d;
    end

    // next state: a handshake on the expiry cycle beats the watchdog
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_FETCH_REQ:  state_d = bus.ifu_gnt ? ST_FETCH_WAIT : expire ? ST_HALT : ST_FETCH_REQ;
            ST_FETCH_WAIT: state_d = bus.ifu_rvalid ? ST_EXEC : expire ? ST_HALT : ST_FETCH_WAIT;
            ST_EXEC:       state_d = (inst_q == EBREAK_INST) ? ST_HALT : is_mem_op(op) ? ST_MEM_REQ : ST_WB;
            ST_MEM_REQ:    state_d = bus.lsu_gnt ? ST_MEM_WAIT : expire ? ST_HALT : ST_MEM_REQ;
            ST_MEM_WAIT:   state_d = bus.lsu_rvalid ? ST_WB : expire ? ST_HALT : ST_MEM_WAIT;
            ST_WB:         state_d = (bus.pc_next[1:0] != 2'b00) ? ST_HALT : ST_FETCH_REQ;
            default:       state_d = ST_HALT;
        endcase
    end

    // architectural registers: pc and retire count move only on an aligned write-back
    always_comb begin
        inst_d    = (state_q == ST_FETCH_WAIT && bus.ifu_rvalid) ? bus.ifu_rdata : inst_q;
        pc_d      = wb_ok ? bus.pc_next : pc_q;
        retired_d = retired_q + {31'd0, wb_ok};
        halted_d  = halted_q | (state_d == ST_HALT);
        trap_d    = trap_q | (state_d == ST_HALT && state_q != ST_EXEC && state_q != ST_HALT);
    end

    // datapath register bank with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            pc_q      <= RESET_PC;
            inst_q    <= 32'd0;
            retired_q <= 32'd0;
            halted_q  <= 1'b0;
            trap_q    <= 1'b0;
        end else begin
            pc_q      <= pc_d;
            inst_q    <= inst_d;
            retired_q <= retired_d;
            halted_q  <= halted_d;
            trap_q    <= trap_d;
        end
    end

    // bus requests and write enable decoded from the current state
    always_comb begin
        bus.ifu_req  = state_q == ST_FETCH_REQ;
        bus.lsu_req  = state_q == ST_MEM_REQ;
        bus.rf_wen   = wb_ok && op != OP_STORE && op != OP_BRANCH && inst_q[11:7] != 5'd0;
        bus.ifu_addr = pc_q;
        bus.pc       = pc_q;
        bus.inst     = inst_q;
        bus.retired  = retired_q;
        bus.halted   = halted_q;
        bus.trap     = trap_q;
    end

endmodule

// File: tb/tb_npc_seq_ctrl.sv
// tb_npc_seq_ctrl: randomized self-checking bench with a transaction-level sequencer model
module tb_npc_seq_ctrl;

    localparam int T = 8;
    localparam logic [31:0] EBRK = 32'h00100073;
    localparam logic [31:0] ADDI = 32'h00100093;

    logic clk = 1'b0;
    logic reset = 1'b0;
    npc_seq_ctrl_if bus();

    npc_seq_ctrl #(.TIMEOUT(16'(T))) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int errs = 0;
    int checks = 0;
    logic chk_en = 1'b0;
    logic exp_ireq, exp_lreq, exp_wen;
    logic [31:0] m_pc, m_inst, m_ret;
    logic m_halt, m_trap;
    int lreq_cnt = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic rb();
        return 1'($urandom);
    endfunction

    // compare every output against the model in mid-cycle
    always @(negedge clk) begin
        if (bus.lsu_req === 1'b1) lreq_cnt++;
        if (chk_en) begin
            chk("ifu_req", 32'(bus.ifu_req), 32'(exp_ireq));
            chk("lsu_req", 32'(bus.lsu_req), 32'(exp_lreq));
            chk("rf_wen", 32'(bus.rf_wen), 32'(exp_wen));
            chk("ifu_addr", bus.ifu_addr, m_pc);
            chk("pc", bus.pc, m_pc);
            chk("inst", bus.inst, m_inst);
            chk("retired", bus.retired, m_ret);
            chk("halted", 32'(bus.halted), 32'(m_halt));
            chk("trap", 32'(bus.trap), 32'(m_trap));
        end
    end

    task automatic cyc(input logic g, input logic rv, input logic [31:0] rd, input logic lg,
                       input logic lr, input logic [31:0] npc, input logic ei, input logic el,
                       input logic ew);
        bus.ifu_gnt    = g;
        bus.ifu_rvalid = rv;
        bus.ifu_rdata  = rd;
        bus.lsu_gnt    = lg;
        bus.lsu_rvalid = lr;
        bus.pc_next    = npc;
        exp_ireq = ei;
        exp_lreq = el;
        exp_wen  = ew;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        chk_en = 1'b0;
        reset = 1'b0;
        cyc(rb(), rb(), $urandom, rb(), rb(), $urandom, 1'b0, 1'b0, 1'b0);
        reset = 1'b1;
        m_pc = 32'h80000000;
        m_inst = 32'd0;
        m_ret = 32'd0;
        m_halt = 1'b0;
        m_trap = 1'b0;
        chk_en = 1'b1;
    endtask

    task automatic halt_cycles(input int n);
        for (int i = 0; i < n; i++) cyc(rb(), rb(), $urandom, rb(), rb(), $urandom, 1'b0, 1'b0, 1'b0);
    endtask

    // one instruction: delays count cycles spent waiting in each handshake phase
    task automatic run(input logic [31:0] ins, input int gd, input int rd, input int lg, input int lr,
                       input logic [31:0] npc, input int rst_mw);
        logic [6:0] op;
        logic mis, wen;
        int i;
        op = ins[6:0];
        i = 0;
        while (1) begin
            cyc(i == gd, rb(), $urandom, rb(), rb(), $urandom, 1'b1, 1'b0, 1'b0);
            if (i == gd) break;
            if (i == T - 1) begin m_halt = 1'b1; m_trap = 1'b1; return; end
            i++;
        end
        i = 0;
        while (1) begin
            cyc(rb(), i == rd, (i == rd) ? ins : $urandom, rb(), rb(), $urandom, 1'b0, 1'b0, 1'b0);
            if (i == rd) begin m_inst = ins; break; end
            if (i == T - 1) begin m_halt = 1'b1; m_trap = 1'b1; return; end
            i++;
        end
        cyc(rb(), rb(), $urandom, rb(), rb(), $urandom, 1'b0, 1'b0, 1'b0);
        if (ins == EBRK) begin m_halt = 1'b1; return; end
        if (op == 7'b0000011 || op == 7'b0100011) begin
            i = 0;
            while (1) begin
                cyc(rb(), rb(), $urandom, i == lg, 1'b0, $urandom, 1'b0, 1'b1, 1'b0);
                if (i == lg) break;
                if (i == T - 1) begin m_halt = 1'b1; m_trap = 1'b1; return; end
                i++;
            end
            i = 0;
            while (1) begin
                if (i == rst_mw) begin do_reset(); return; end
                cyc(rb(), rb(), $urandom, rb(), i == lr, $urandom, 1'b0, 1'b0, 1'b0);
                if (i == lr) break;
                if (i == T - 1) begin m_halt = 1'b1; m_trap = 1'b1; return; end
                i++;
            end
        end
        mis = npc[1:0] != 2'b00;
        wen = !mis && op != 7'b0100011 && op != 7'b1100011 && ins[11:7] != 5'd0;
        cyc(rb(), rb(), $urandom, rb(), rb(), npc, 1'b0, 1'b0, wen);
        if (mis) begin
            m_halt = 1'b1;
            m_trap = 1'b1;
        end else begin
            m_pc = npc;
            m_ret = m_ret + 32'd1;
        end
    endtask

    function automatic int dly();
        return ($urandom_range(0, 14) == 0) ? int'($urandom_range(6, 10)) : int'($urandom_range(0, 3));
    endfunction

    initial begin
        logic [31:0] r, ins, npc;
        int lr, mw;
        bus.ifu_gnt = 1'b0;
        bus.ifu_rvalid = 1'b0;
        bus.ifu_rdata = 32'd0;
        bus.lsu_gnt = 1'b0;
        bus.lsu_rvalid = 1'b0;
        bus.pc_next = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        do_reset();
        chk("rst_pc", bus.pc, 32'h80000000);
        chk("rst_ifu_req", 32'(bus.ifu_req), 32'd1);
        run(ADDI, 0, 0, 0, 0, 32'h80000004, -1);
        chk("alu_pc", bus.pc, 32'h80000004);
        chk("alu_retired", bus.retired, 32'd1);
        do_reset();
        run(EBRK, 1, 1, 0, 0, 32'h80000004, -1);
        halt_cycles(20);
        chk("ebrk_halted", 32'(bus.halted), 32'd1);
        chk("ebrk_trap", 32'(bus.trap), 32'd0);
        chk("ebrk_pc", bus.pc, 32'h80000000);
        do_reset();
        lreq_cnt = 0;
        run(32'h00112023, 0, 0, 3, 0, 32'h80000004, -1);
        chk("st_lsu_req_cycles", 32'(lreq_cnt), 32'd4);
        chk("st_retired", bus.retired, 32'd1);
        do_reset();
        run(ADDI, 20, 0, 0, 0, 32'h80000004, -1);
        chk("wdog_trap", 32'(bus.trap), 32'd1);
        chk("wdog_halted", 32'(bus.halted), 32'd1);
        halt_cycles(3);
        do_reset();
        run(ADDI, T - 1, 0, 0, 0, 32'h80000004, -1);
        chk("wdog_edge_trap", 32'(bus.trap), 32'd0);
        chk("wdog_edge_retired", bus.retired, 32'd1);
        do_reset();
        run(ADDI, 0, 0, 0, 0, 32'h80000006, -1);
        chk("mis_trap", 32'(bus.trap), 32'd1);
        chk("mis_pc", bus.pc, 32'h80000000);
        chk("mis_retired", bus.retired, 32'd0);
        do_reset();
        run(ADDI, 0, 0, 0, 0, 32'h80000004, -1);
        run(32'h00012083, 0, 0, 0, 5, 32'h80000008, 2);
        chk("mwrst_pc", bus.pc, 32'h80000000);
        chk("mwrst_retired", bus.retired, 32'd0);
        chk("mwrst_lsu_req", 32'(bus.lsu_req), 32'd0);
        run(ADDI, 1, 0, 0, 0, 32'h80000004, -1);
        for (int n = 0; n < 300; n++) begin
            if (m_halt) begin
                halt_cycles(3);
                do_reset();
            end
            r = $urandom;
            case ($urandom_range(0, 9))
                0, 1, 2, 3: ins = {r[31:7], r[0] ? 7'b0010011 : 7'b0110011};
                4, 5:       ins = {r[31:7], 7'b0000011};
                6, 7:       ins = {r[31:7], 7'b0100011};
                8:          ins = {r[31:7], 7'b1100011};
                default:    ins = ($urandom_range(0, 2) == 0) ? EBRK : {r[31:7], 7'b0110111};
            endcase
            if (r[1] && r[2] && r[3]) ins[11:7] = 5'd0;
            npc = ($urandom_range(0, 19) == 0) ? m_pc + 32'(2 * $urandom_range(0, 1) + 1)
                                               : m_pc + 32'(4 * $urandom_range(1, 8));
            lr = dly();
            mw = ($urandom_range(0, 24) == 0) ? int'($urandom_range(0, (lr < T - 1) ? lr : T - 1)) : -1;
            run(ins, dly(), dly(), dly(), lr, npc, mw);
        end
        halt_cycles(2);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
